// File: rtl/delay_line_ctrl_if.sv
// Control bundle between a delay-line controller and its user/RAM side.
// AWIDTH must match the AWIDTH of the delay_line_ctrl instance it connects to.
interface delay_line_ctrl_if #(
   parameter int unsigned AWIDTH = 6
) ();
   logic              enable;
   logic [AWIDTH-1:0] delay_len;
   logic              flush;
   logic              input_strobe;
   logic              ram_we;
   logic [AWIDTH-1:0] ram_waddr;
   logic              ram_re;
   logic [AWIDTH-1:0] ram_raddr;
   logic              output_strobe;
   logic              primed;
   logic [AWIDTH-1:0] fill_level;

   // Sample source / configuration side
   modport master (
      output enable, delay_len, flush, input_strobe,
      input  ram_we, ram_waddr, ram_re, ram_raddr, output_strobe, primed, fill_level
   );

   // Controller side
   modport slave (
      input  enable, delay_len, flush, input_strobe,
      output ram_we, ram_waddr, ram_re, ram_raddr, output_strobe, primed, fill_level
   );
endinterface

// File: rtl/delay_line_ctrl.sv
// Address/strobe controller for a circular-buffer delay line on a dual-port RAM
// with 1-cycle read latency. Port A writes incoming samples at the write pointer,
// port B reads the sample written dly strobes earlier.
module delay_line_ctrl #(
   parameter int unsigned AWIDTH = 6
) (
   input logic                 clock,
   input logic                 reset,
   delay_line_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {StIdle, StFill, StRun, StFlush} state_e;

   state_e            state_q, state_d;
   logic [AWIDTH-1:0] wptr_q, wptr_d;
   logic [AWIDTH-1:0] fill_q, fill_d;
   logic [AWIDTH-1:0] dly_q, dly_d;
   logic              ostrb_q;
   logic              accepted;
   logic              rd_en;

   // A strobe only counts while the line is active and no flush is pending
   always_comb begin
      accepted = bus.input_strobe & bus.enable & ~bus.flush &
                 ((state_q == StFill) | (state_q == StRun));
      rd_en    = accepted & (state_q == StRun);
   end

   // Next-state logic; enable low freezes everything
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      fill_d  = fill_q;
      dly_d   = dly_q;
      if (bus.enable) begin
         unique case (state_q)
            StIdle: begin
               state_d = StFill;
               // A zero delay would make read and write addresses collide
               dly_d   = (bus.delay_len == '0) ? AWIDTH'(1) : bus.delay_len;
               wptr_d  = '0;
               fill_d  = '0;
            end
            StFill: begin
               if (bus.flush) begin
                  state_d = StFlush;
                  wptr_d  = '0;
                  fill_d  = '0;
               end else if (accepted) begin
                  wptr_d = wptr_q + AWIDTH'(1);
                  fill_d = fill_q + AWIDTH'(1);
                  if (fill_q == dly_q - AWIDTH'(1)) begin
                     state_d = StRun;
                  end
               end
            end
            StRun: begin
               if (bus.flush) begin
                  state_d = StFlush;
                  wptr_d  = '0;
                  fill_d  = '0;
               end else if (accepted) begin
                  wptr_d = wptr_q + AWIDTH'(1);
               end
            end
            StFlush: begin
               state_d = StIdle;
               wptr_d  = '0;
               fill_d  = '0;
            end
         endcase
      end
   end

   // State registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         wptr_q  <= '0;
         fill_q  <= '0;
         dly_q   <= AWIDTH'(1);
         ostrb_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         fill_q  <= fill_d;
         dly_q   <= dly_d;
         ostrb_q <= rd_en;
      end
   end

   // Outputs; combinational ones are forced low while reset is held
   always_comb begin
      bus.ram_we        = accepted & ~reset;
      bus.ram_re        = rd_en & ~reset;
      bus.ram_raddr     = reset ? '0 : (wptr_q - dly_q);
      bus.ram_waddr     = wptr_q;
      bus.fill_level    = fill_q;
      bus.primed        = (state_q == StRun);
      bus.output_strobe = ostrb_q;
   end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl: a count-based reference model plus a
// behavioural dual-port RAM, with directed scenarios and randomized traffic.
module tb_delay_line_ctrl;

   localparam int unsigned AW = 6;

   logic        clock;
   logic        reset;
   logic [31:0] wdata;
   logic [31:0] dob;
   logic [31:0] mem [64];

   int n_err    = 0;
   int n_checks = 0;

   // Reference model: phase 0=idle, 1=active (fill or run), 2=flush
   int          m_phase;
   int          m_n;
   int          m_dly;
   bit          m_os;
   logic [31:0] m_dob;
   logic [31:0] samples [$];
   logic [31:0] obs [$];
   logic [31:0] ins [$];

   delay_line_ctrl_if #(.AWIDTH(AW)) bus ();

   delay_line_ctrl #(.AWIDTH(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural RAM: write port A, registered read port B
   always @(posedge clock) begin
      if (bus.ram_we) mem[bus.ram_waddr] <= wdata;
      if (bus.ram_re) dob <= mem[bus.ram_raddr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_n     = 0;
      m_dly   = 1;
      m_os    = 1'b0;
      samples.delete();
   endtask

   // Compare process: check at negedge, advance model at posedge
   always begin
      bit acc, run, exp_re;
      @(negedge clock);
      if (reset) model_reset();
      acc    = !reset && bus.enable && bus.input_strobe && !bus.flush && (m_phase == 1);
      run    = (m_phase == 1) && (m_n >= m_dly);
      exp_re = acc && run;
      check("ram_we", bus.ram_we, acc);
      check("ram_re", bus.ram_re, exp_re);
      check("ram_waddr", bus.ram_waddr, m_n & 63);
      check("ram_raddr", bus.ram_raddr, reset ? 0 : ((m_n - m_dly) & 63));
      check("fill_level", bus.fill_level, (m_n < m_dly) ? m_n : m_dly);
      check("primed", bus.primed, run);
      check("output_strobe", bus.output_strobe, m_os);
      if (m_os && !reset) check("dob", dob, m_dob);
      if (bus.output_strobe && !reset) obs.push_back(dob);
      @(posedge clock);
      if (reset) begin
         model_reset();
      end else begin
         acc  = bus.enable && bus.input_strobe && !bus.flush && (m_phase == 1);
         run  = (m_phase == 1) && (m_n >= m_dly);
         m_os = acc && run;
         if (m_os) m_dob = samples[m_n - m_dly];
         if (bus.enable) begin
            case (m_phase)
               0: begin
                  m_phase = 1;
                  m_dly   = (bus.delay_len == 0) ? 1 : int'(bus.delay_len);
                  m_n     = 0;
                  samples.delete();
               end
               1: begin
                  if (bus.flush) begin
                     m_phase = 2;
                     m_n     = 0;
                  end else if (acc) begin
                     samples.push_back(wdata);
                     m_n++;
                  end
               end
               default: m_phase = 0;
            endcase
         end
      end
   end

   task automatic drive(input bit en, input bit st, input bit fl, input int dl,
                        input logic [31:0] d);
      @(posedge clock);
      #2;
      bus.enable       = en;
      bus.input_strobe = st;
      bus.flush        = fl;
      bus.delay_len    = AW'(dl);
      wdata            = d;
   endtask

   // Flush from FILL/RUN, pass through FLUSH and IDLE, latch dl entering FILL
   task automatic go_idle(input int dl);
      drive(1, 0, 1, dl, 0);
      drive(1, 0, 0, dl, 0);
      drive(1, 0, 0, dl, 0);
      obs.delete();
   endtask

   // delay 5, samples 0..19 back to back from IDLE
   task automatic run_basic();
      obs.delete();
      drive(1, 0, 0, 5, 0);
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 0, 5, i);
         if (i == 4) begin
            #1;
            check("basic_fill4", bus.fill_level, 4);
            check("basic_primed_lo", bus.primed, 0);
         end
         if (i == 5) begin
            #1;
            check("basic_fill5", bus.fill_level, 5);
            check("basic_primed_hi", bus.primed, 1);
         end
      end
      repeat (3) drive(1, 0, 0, 5, 0);
      check("basic_count", obs.size(), 15);
      if (obs.size() == 15) begin
         for (int k = 0; k < 15; k++) check("basic_data", obs[k], k);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] d;
      int          gap;
      reset            = 1'b1;
      bus.enable       = 1'b0;
      bus.input_strobe = 1'b0;
      bus.flush        = 1'b0;
      bus.delay_len    = '0;
      wdata            = '0;
      #1;
      check("rst_raddr", bus.ram_raddr, 0);
      check("rst_primed", bus.primed, 0);
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;

      // Continuous strobes, delay 5
      run_basic();

      // Delay 63 with random gaps, random enable drops and delay_len churn
      go_idle(63);
      ins.delete();
      for (int s = 0; s < 200; s++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            if ($urandom_range(0, 1) == 1) drive(0, 1, 0, $urandom, $urandom);
            else                           drive(1, 0, 0, $urandom, $urandom);
         end
         d = $urandom;
         drive(1, 1, 0, $urandom, d);
         ins.push_back(d);
      end
      repeat (2) drive(1, 0, 0, 0, 0);
      check("d63_count", obs.size(), 137);
      if (obs.size() == 137) begin
         for (int k = 0; k < 137; k++) check("d63_data", obs[k], ins[k]);
      end

      // delay_len 0 behaves as 1
      go_idle(0);
      for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 100 + i);
      repeat (2) drive(1, 0, 0, 0, 0);
      check("d0_count", obs.size(), 2);
      if (obs.size() == 2) begin
         check("d0_first", obs[0], 100);
         check("d0_second", obs[1], 101);
      end

      // Flush coincident with a strobe and a delay change
      go_idle(8);
      for (int i = 0; i < 10; i++) drive(1, 1, 0, 8, 200 + i);
      drive(1, 1, 1, 3, 999);
      drive(1, 0, 0, 3, 0);
      drive(1, 0, 0, 3, 0);
      obs.delete();
      for (int i = 0; i < 6; i++) drive(1, 1, 0, 3, 300 + i);
      repeat (2) drive(1, 0, 0, 3, 0);
      check("flush_count", obs.size(), 3);
      if (obs.size() == 3) begin
         check("flush_first", obs[0], 300);
         check("flush_third", obs[2], 302);
      end

      // Enable low mid-FILL with strobes asserted
      go_idle(10);
      for (int i = 0; i < 4; i++) drive(1, 1, 0, 10, 400 + i);
      repeat (10) drive(0, 1, 0, 10, 7);
      #1;
      check("hold_fill", bus.fill_level, 4);
      check("hold_waddr", bus.ram_waddr, 4);
      check("hold_primed", bus.primed, 0);
      for (int i = 4; i < 12; i++) drive(1, 1, 0, 10, 400 + i);

      // Asynchronous reset between edges while in RUN
      drive(1, 1, 0, 10, 500);
      @(posedge clock);
      #1;
      check("pre_rst_ostrb", bus.output_strobe, 1);
      check("pre_rst_primed", bus.primed, 1);
      #2 reset = 1'b1;
      #1;
      check("async_rst_ostrb", bus.output_strobe, 0);
      check("async_rst_primed", bus.primed, 0);
      check("async_rst_we", bus.ram_we, 0);
      drive(0, 0, 0, 5, 0);
      @(posedge clock);
      #2 reset = 1'b0;
      run_basic();

      repeat (2) drive(0, 0, 0, 0, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
